// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one 16x16 multiplier between NREQ requesters.
// Optional build macro MUL_ARB_PRIO0_EN gives requester 0 absolute priority over the rest.
module mul_share_arb #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [16*NREQ-1:0]      req_a,
  input  logic [16*NREQ-1:0]      req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy,
  output logic                    mul_start,
  output logic [15:0]             mul_a,
  output logic [15:0]             mul_b,
  input  logic                    mul_finish,
  input  logic [31:0]             mul_y
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;
  logic [15:0]    op_a;
  logic [15:0]    op_b;
  logic           first_wait;

  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           win_found;
  logic           grant;
  logic           drive_ops;

  // Winner search: first pending requester at or above ptr, wrapping modulo NREQ.
  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    win       = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDW'(k);
`ifdef MUL_ARB_PRIO0_EN
      if (!win_found && cand != '0 && req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
`else
      if (!win_found && req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
`endif
    end
`ifdef MUL_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win       = '0;
      win_found = 1'b1;
    end
`endif
  end

  // A grant needs an idle multiplier; this also keeps a post-reset IDLE from
  // starting a new operation while a discarded one is still running.
  assign grant = (state == S_IDLE) && mul_finish && win_found && !rst;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (grant) req_ready[win] = 1'b1;
    if (state == S_DONE) rsp_valid[owner] = 1'b1;
  end

  assign busy      = (state != S_IDLE);
  assign mul_start = (state == S_ISSUE);
  assign drive_ops = (state == S_ISSUE) || (state == S_WAIT);
  assign mul_a     = drive_ops ? op_a : 16'h0000;
  assign mul_b     = drive_ops ? op_b : 16'h0000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      first_wait <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            op_a  <= req_a[16*win +: 16];
            op_b  <= req_b[16*win +: 16];
            owner <= win;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          first_wait <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // The multiplier may not have dropped its idle flag yet in the first WAIT cycle.
          first_wait <= 1'b0;
          if (!first_wait && mul_finish) begin
            rsp_data <= mul_y;
            rsp_id   <= owner;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef MUL_ARB_PRIO0_EN
          if (owner != '0) ptr <= owner + IDW'(1);
`else
          ptr <= owner + IDW'(1);
`endif
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: table of single operations plus
// hand-written sequences for round-robin, reissue, reset, withdraw and priority.
module tb_mul_share_arb;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int MUL_L = 7;
  localparam int NVEC  = 8;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    a;
    logic [15:0]    b;
    logic [31:0]    p;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 busy;
  logic                 mul_start;
  logic [15:0]          mul_a;
  logic [15:0]          mul_b;
  logic                 mul_finish;
  logic [31:0]          mul_y;

  int n_cmp = 0;
  int n_bad = 0;
  int gq[$];
  int gc[$];
  int n_rsp;

  vec_t        vecs[NVEC];
  logic [15:0] sa[NREQ];
  logic [15:0] sb[NREQ];
  logic [31:0] sp[NREQ];
  int          rr_exp[5];
  int          pr_exp[4];

  always #5 clk = ~clk;

  mul_share_arb #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_finish (mul_finish),
    .mul_y      (mul_y)
  );

  // Multiplier model: idle flag drops for MUL_L cycles after start. In lag mode
  // the flag stays high for one extra cycle first, so the total latency is the same.
  logic [3:0] mul_cnt  = '0;
  logic       mul_lag  = 1'b0;
  logic       lag_pend = 1'b0;

  assign mul_finish = (mul_cnt == 4'd0);
  assign mul_y      = {16'h0000, mul_a} * {16'h0000, mul_b};

  always @(posedge clk) begin
    if (mul_start) begin
      if (mul_lag) begin
        lag_pend <= 1'b1;
        mul_cnt  <= '0;
      end else begin
        mul_cnt <= 4'(MUL_L);
      end
    end else if (lag_pend) begin
      lag_pend <= 1'b0;
      mul_cnt  <= 4'(MUL_L - 1);
    end else if (mul_cnt != 4'd0) begin
      mul_cnt <= mul_cnt - 4'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    oh_idx = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) oh_idx = i;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_single(input vec_t v);
    logic [NREQ-1:0] oh;
    int t;
    oh = '0;
    oh[v.id] = 1'b1;
    @(negedge clk);
    req_valid = oh;
    req_a[16*v.id +: 16] = v.a;
    req_b[16*v.id +: 16] = v.b;
    #1;
    check("single_grant", req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_start", mul_start, 1);
    check("single_mul_a", mul_a, v.a);
    check("single_mul_b", mul_b, v.b);
    check("single_busy", busy, 1);
    t = 1;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (rsp_valid == '0 && t < 30);
    check("single_latency", t, 10);
    check("single_rsp_valid", rsp_valid, oh);
    check("single_rsp_id", rsp_id, v.id);
    check("single_rsp_data", rsp_data, v.p);
    @(negedge clk);
    #1;
    check("single_rsp_pulse", rsp_valid, 0);
    check("single_idle_busy", busy, 0);
    check("single_idle_mul_a", mul_a, 0);
    check("single_rsp_hold", rsp_data, v.p);
  endtask

  // Requesters in mask request continuously: drop on grant, reissue the cycle after rsp_valid.
  task automatic run_stream(input logic [NREQ-1:0] mask, input int n);
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] set;
    logic [NREQ-1:0] oh;
    clr = '0;
    set = '0;
    gq.delete();
    gc.delete();
    n_rsp = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = sa[i];
      req_b[16*i +: 16] = sb[i];
    end
    for (int c = 0; c < n * 11; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = mask;
      else        req_valid = (req_valid & ~clr) | set;
      clr = '0;
      set = '0;
      #1;
      if (req_ready != '0) begin
        gq.push_back(oh_idx(req_ready));
        gc.push_back(c);
        clr = req_ready;
      end
      if (rsp_valid != '0) begin
        oh = '0;
        oh[rsp_id] = 1'b1;
        n_rsp++;
        check("stream_rsp_onehot", rsp_valid, oh);
        check("stream_rsp_data", rsp_data, sp[rsp_id]);
        set = rsp_valid & mask;
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    int stray;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    vecs[0] = '{2'd1, 16'h1234, 16'h5678, 32'h06260060};
    vecs[1] = '{2'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{2'd0, 16'h0000, 16'h1234, 32'h00000000};
    vecs[3] = '{2'd2, 16'h0001, 16'hABCD, 32'h0000ABCD};
    vecs[4] = '{2'd0, 16'h8000, 16'h0002, 32'h00010000};
    vecs[5] = '{2'd3, 16'h00FF, 16'h0100, 32'h0000FF00};
    vecs[6] = '{2'd2, 16'h1000, 16'h1000, 32'h01000000};
    vecs[7] = '{2'd1, 16'hFFFF, 16'h0002, 32'h0001FFFE};

    sa[0] = 16'h1234; sb[0] = 16'h5678; sp[0] = 32'h06260060;
    sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; sp[1] = 32'hFFFE0001;
    sa[2] = 16'h0003; sb[2] = 16'h0005; sp[2] = 32'h0000000F;
    sa[3] = 16'h0100; sb[3] = 16'h0100; sp[3] = 32'h00010000;

`ifdef MUL_ARB_PRIO0_EN
    rr_exp = '{0, 0, 0, 0, 0};
    pr_exp = '{0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 3, 0};
    pr_exp = '{0, 2, 0, 2};
`endif

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_mul_start", mul_start, 0);
    check("reset_mul_a", mul_a, 0);
    check("reset_mul_b", mul_b, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_single(vecs[i]);

    // All four continuous from ptr=0.
    do_reset();
    run_stream(4'b1111, 5);
    check("rr_grant_count", gq.size(), 5);
    check("rr_rsp_count", n_rsp, 5);
    for (int k = 0; k < 5; k++) begin
      check("rr_order", (gq.size() > k) ? gq[k] : -1, rr_exp[k]);
      check("rr_slot", (gc.size() > k) ? gc[k] : -1, 11 * k);
    end

    // Owner reissues right after its response while req 2 waits; lagging idle flag.
    do_reset();
    mul_lag = 1'b1;
    stray   = 0;
    req_a[16*1 +: 16] = 16'h0007; req_b[16*1 +: 16] = 16'h0009;
    req_a[16*2 +: 16] = 16'h0010; req_b[16*2 +: 16] = 16'h0010;
    for (int t = 0; t <= 33; t++) begin
      @(negedge clk);
      case (t)
        0:  req_valid = 4'b0010;
        1:  req_valid = 4'b0000;
        3:  req_valid = 4'b0100;
        11: req_valid = 4'b0110;
        12: req_valid = 4'b0010;
        23: req_valid = 4'b0000;
        default: ;
      endcase
      #1;
      case (t)
        0:  check("reissue_grant1", req_ready, 4'b0010);
        10: begin
          check("reissue_rsp1_valid", rsp_valid, 4'b0010);
          check("reissue_rsp1_id", rsp_id, 1);
          check("reissue_rsp1_data", rsp_data, 32'h0000003F);
          check("reissue_done_no_grant", req_ready, 0);
        end
        11: check("reissue_grant2_first", req_ready, 4'b0100);
        21: begin
          check("reissue_rsp2_valid", rsp_valid, 4'b0100);
          check("reissue_rsp2_data", rsp_data, 32'h00000100);
        end
        22: check("reissue_grant1_again", req_ready, 4'b0010);
        32: check("reissue_rsp1b_data", rsp_data, 32'h0000003F);
        default: if (req_ready != '0 || rsp_valid != '0) stray++;
      endcase
    end
    check("reissue_stray", stray, 0);
    mul_lag = 1'b0;

    // Reset in WAIT while the multiplier is busy; req 2 must wait for mul_finish.
    stray = 0;
    req_a[16*0 +: 16] = 16'h0002; req_b[16*0 +: 16] = 16'h0003;
    req_a[16*2 +: 16] = 16'h0011; req_b[16*2 +: 16] = 16'h0011;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      case (t)
        0:  req_valid = 4'b0001;
        1:  req_valid = 4'b0000;
        3:  req_valid = 4'b0100;
        4:  rst = 1'b1;
        5:  rst = 1'b0;
        10: req_valid = 4'b0000;
        default: ;
      endcase
      #1;
      case (t)
        0: check("rstmid_grant0", req_ready, 4'b0001);
        5: begin
          check("rstmid_busy", busy, 0);
          check("rstmid_ready", req_ready, 0);
          check("rstmid_rsp_valid", rsp_valid, 0);
          check("rstmid_mul_a", mul_a, 0);
          check("rstmid_mul_b", mul_b, 0);
          check("rstmid_rsp_data", rsp_data, 0);
          check("rstmid_rsp_id", rsp_id, 0);
        end
        9: check("rstmid_grant2", req_ready, 4'b0100);
        19: begin
          check("rstmid_rsp2_valid", rsp_valid, 4'b0100);
          check("rstmid_rsp2_id", rsp_id, 2);
          check("rstmid_rsp2_data", rsp_data, 32'h00000121);
        end
        default: if (req_ready != '0 || rsp_valid != '0) stray++;
      endcase
    end
    check("rstmid_stray", stray, 0);

    // Req 3 asserts for three WAIT cycles then withdraws.
    stray = 0;
    req_a[16*0 +: 16] = 16'h0004; req_b[16*0 +: 16] = 16'h0005;
    req_a[16*3 +: 16] = 16'h00AA; req_b[16*3 +: 16] = 16'h0002;
    for (int t = 0; t <= 25; t++) begin
      @(negedge clk);
      case (t)
        0: req_valid = 4'b0001;
        1: req_valid = 4'b0000;
        3: req_valid = 4'b1000;
        6: req_valid = 4'b0000;
        default: ;
      endcase
      #1;
      case (t)
        0:  check("withdraw_grant0", req_ready, 4'b0001);
        10: begin
          check("withdraw_rsp0_valid", rsp_valid, 4'b0001);
          check("withdraw_rsp0_data", rsp_data, 32'h00000014);
        end
        default: if (req_ready != '0 || rsp_valid != '0) stray++;
      endcase
    end
    check("withdraw_stray", stray, 0);

    // Requesters 0 and 2 continuous.
    do_reset();
    run_stream(4'b0101, 4);
    check("prio_grant_count", gq.size(), 4);
    check("prio_rsp_count", n_rsp, 4);
    for (int k = 0; k < 4; k++) begin
      check("prio_order", (gq.size() > k) ? gq[k] : -1, pr_exp[k]);
      check("prio_slot", (gc.size() > k) ? gc[k] : -1, 11 * k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one 16x16 multiplier between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues a one-cycle start to the multiplier. It then waits on the multiplier's finish flag, captures the 32-bit product and returns it with a one-cycle response pulse to the owning requester. It sits between the execution units and the shared multiplier, which provides op_start, mul_finish, A, B and a combinational Y.

## Interface
- NREQ, 4, number of requesters; power of two, 2..8
- IDW, clog2(NREQ), requester index width (localparam, derived)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NREQ  bit i: requester i has an operand pair pending
- req_a  in  16*NREQ  operand A of requester i at [16*i+15:16*i]
- req_b  in  16*NREQ  operand B of requester i, same packing
- req_ready  out  NREQ  one-hot; bit i high for the single cycle requester i is granted
- rsp_valid  out  NREQ  one-hot one-cycle pulse: product for requester i on rsp_data
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_data  out  32  registered unsigned product; held until the next capture
- busy  out  1  high whenever state is not IDLE
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a, mul_b  out  16 each  operands to the multiplier; held stable from ISSUE through WAIT
- mul_finish  in  1  multiplier idle/done flag (high = idle)
- mul_y  in  32  multiplier product (combinational on mul_a, mul_b)

## Operation
- States: IDLE, ISSUE, WAIT, DONE. The state, owner index, round-robin pointer ptr, operand latches and rsp_data are registered.
- IDLE: a grant is made only when mul_finish=1 and at least one req_valid bit is set.
  - The winner is the first set req_valid bit searching from ptr upward, mod NREQ.
  - req_ready[winner]=1 combinationally in that cycle.
  - req_a and req_b slices of the winner are latched, owner=winner, next=ISSUE.
  - Otherwise the block stays in IDLE.
- ISSUE: mul_start=1, mul_a and mul_b driven from the latches, next=WAIT.
- WAIT: the first WAIT cycle ignores mul_finish (start guard).
  - On later cycles, mul_finish=1 captures mul_y into rsp_data and owner into rsp_id, next=DONE.
- DONE: rsp_valid[owner]=1, ptr<=owner+1 mod NREQ, next=IDLE.
- Arithmetic: unsigned 16x16->32. The block does no arithmetic itself; rsp_data = mul_y exactly.
- Requester rules:
  - A requester holds req_valid and its operands until it sees req_ready.
  - A requester may drop req_valid before it is granted (withdraw); it is then not granted.
  - A requester must not reissue until it sees rsp_valid.
- Only one operation is in flight. Requests arriving in ISSUE, WAIT or DONE wait; req_ready stays 0.
- Simultaneous events:
  - In DONE, no grant is made in the same cycle, even with req_valid set.
  - The owner's new request is considered in the following IDLE cycle, at the lowest priority under the updated ptr.
- Reset (rst=1 at an edge), including mid-operation:
  - state=IDLE, ptr=0, owner=0, rsp_data=0, rsp_id=0, latches=0.
  - Any in-flight result is discarded and no rsp_valid is issued.
  - If the multiplier is still busy afterward, IDLE waits for mul_finish=1 before granting.
- Output values in reset and in IDLE: req_ready=0 except when granting, rsp_valid=0, mul_start=0, busy=0, mul_a=mul_b=0.

## Timing
- Grant at cycle t0; ISSUE (mul_start) at t0+1; WAIT from t0+2.
- If mul_finish is low for L cycles after start, capture is at t0+L+2 and rsp_valid is at t0+L+3.
- With the current multiplier (L=7): rsp_valid at t0+10.
- Back-to-back throughput: one operation per L+4 cycles. With the current multiplier, the next grant is earliest at t0+11.
- rsp_data and rsp_id are valid from the rsp_valid cycle and stable until the next capture.
- There is no combinational path from mul_y to any output; the req_valid->req_ready path is combinational.

## Configuration
- MUL_ARB_PRIO0_EN defined:
  - Requester 0 wins whenever req_valid[0]=1 in a granting IDLE cycle.
  - Requesters 1..NREQ-1 share round-robin among themselves.
  - ptr is updated only on grants to requesters 1..NREQ-1.
- MUL_ARB_PRIO0_EN undefined: pure round-robin over all NREQ requesters as described above.

## Test plan
- Single request: rst 2 cycles, then req 1 with A=0x1234, B=0x5678 -> req_ready=0b0010 at t0, mul_start at t0+1, rsp_valid=0b0010 at t0+10, rsp_id=1, rsp_data=0x06260060.
- All four request continuously from ptr=0 -> grants in order 0,1,2,3,0, spaced 11 cycles. Each response equals its own product; corner case A=B=0xFFFF -> 0xFFFE0001.
- Owner reissues in the cycle after rsp_valid while req 2 is pending -> req 2 is granted first.
- Reset mid-WAIT (multiplier busy) -> no rsp_valid, outputs return to reset values, and no grant until mul_finish=1.
- Withdraw: req 3 is asserted for 3 cycles during WAIT then dropped -> req 3 is never granted and no response goes to 3.
- With MUL_ARB_PRIO0_EN: reqs 0 and 2 are continuous -> req 0 is granted every slot; without the macro -> grants alternate 0,2,0,2.
